req_arbiter_rr: RTL and testbench

REQ_ARBITER_RR -- requirements
Module: req_arbiter_rr

---
 rtl/req_arbiter_rr.sv | 149 ++++++++++++++
 tb/tb_req_arbiter_rr.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_rr.sv
// Request arbiter: picks one pending, enabled channel per grant, with optional strict
// priority for channel 0 (bounded by a starvation limit) and round-robin over the rest.
module req_arbiter_rr #(
    parameter int CHN_NUM    = 7,
    parameter int PRIO_EN    = 1,
    parameter int STARVE_LIM = 8,
    parameter int IDX_W      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CHN_NUM-1:0] i_req_empty,
    input  logic [CHN_NUM-1:0] i_chn_mask,
    input  logic               i_receive_req,
    output logic [CHN_NUM-1:0] o_sel_chn,
    output logic [IDX_W-1:0]   o_sel_idx,
    output logic               o_sel_valid,
    output logic [7:0]         o_starve_cnt
);

    localparam int RING_LO = (PRIO_EN != 0) ? 1 : 0;
    localparam int RING_HI = CHN_NUM - 1;
    localparam int RING_N  = RING_HI - RING_LO + 1;
    localparam logic [7:0] STARVE_LIM_8 = 8'(STARVE_LIM);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               arm_q, arm_d;
    logic [CHN_NUM-1:0] sel_chn_q, sel_chn_d;
    logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;
    logic [IDX_W-1:0]   last_rr_q, last_rr_d;
    logic [7:0]         starve_q, starve_d;

    logic [CHN_NUM-1:0] elig;
    logic [IDX_W-1:0]   ring_idx;
    logic [IDX_W-1:0]   next_idx;
    logic               ring_found;
    logic               others_elig;
    logic               prio_hit;
    logic               fallback_hit;
    logic               has_next;
    logic               next_is_ring;
    logic               load;

    // Returns {found, index} of the first eligible ring channel after 'last', wrapping.
    // Offsets are scanned from farthest to nearest so the nearest match is kept.
    function automatic logic [IDX_W:0] ring_search(input logic [CHN_NUM-1:0] elig_v,
                                                   input logic [IDX_W-1:0]   last);
        logic [IDX_W:0] res;
        int             pos;
        res = '0;
        for (int k = RING_N; k >= 1; k--) begin
            pos = int'(last) + k;
            if (pos > RING_HI) pos = pos - RING_N;
            if (elig_v[IDX_W'(pos)]) res = {1'b1, IDX_W'(pos)};
        end
        return res;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [CHN_NUM-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [CHN_NUM-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_comb begin
        elig                   = ~i_req_empty & i_chn_mask;
        {ring_found, ring_idx} = ring_search(elig, last_rr_q);
        others_elig            = |elig[CHN_NUM-1:1];
        prio_hit               = (PRIO_EN != 0) && elig[0] && (starve_q < STARVE_LIM_8);
        // Starved channel 0 still wins when nothing in the ring wants service.
        fallback_hit           = (PRIO_EN != 0) && elig[0] && !ring_found;
        has_next               = prio_hit || ring_found || fallback_hit;
        next_is_ring           = !prio_hit && ring_found;
        next_idx               = next_is_ring ? ring_idx : '0;
    end

    always_comb begin
        state_d   = state_q;
        arm_d     = 1'b1;
        sel_chn_d = sel_chn_q;
        sel_idx_d = sel_idx_q;
        last_rr_d = last_rr_q;
        starve_d  = starve_q;
        load      = 1'b0;

        // arm_q holds off the first grant until the second edge after reset release.
        case (state_q)
            IDLE: begin
                if (arm_q && has_next) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (i_receive_req) begin
                    if (has_next) load    = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sel_chn_d = to_onehot(next_idx);
            sel_idx_d = next_idx;
            if (next_is_ring) begin
                last_rr_d = next_idx;
                starve_d  = '0;
            end else if (others_elig) begin
                starve_d = sat_inc8(starve_q);
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arm_q     <= 1'b0;
            sel_chn_q <= '0;
            sel_idx_q <= '0;
            last_rr_q <= IDX_W'(RING_HI);
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            sel_chn_q <= sel_chn_d;
            sel_idx_q <= sel_idx_d;
            last_rr_q <= last_rr_d;
            starve_q  <= starve_d;
        end
    end

    assign o_sel_chn    = sel_chn_q;
    assign o_sel_idx    = sel_idx_q;
    assign o_sel_valid  = (state_q == HOLD);
    assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_req_arbiter_rr.sv
// Directed bench for req_arbiter_rr: expected grants are queued as stimulus is applied
// and popped when the arbiter presents a selection.
module tb_req_arbiter_rr;

    localparam int N = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [N-1:0] empty, mask;
    logic         recv;
    logic [N-1:0] sel_chn;
    logic [2:0]   sel_idx;
    logic         sel_valid;
    logic [7:0]   starve;

    logic [1:0]  e2, m2, c2;
    logic        r2, i2, v2;
    logic [7:0]  s2;
    logic [15:0] e16, m16, c16;
    logic        r16, v16;
    logic [3:0]  i16;
    logic [7:0]  s16;

    req_arbiter_rr #(.CHN_NUM(7), .PRIO_EN(1), .STARVE_LIM(8), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .i_req_empty(empty), .i_chn_mask(mask),
        .i_receive_req(recv), .o_sel_chn(sel_chn), .o_sel_idx(sel_idx),
        .o_sel_valid(sel_valid), .o_starve_cnt(starve));

    req_arbiter_rr #(.CHN_NUM(2), .PRIO_EN(0), .STARVE_LIM(8), .IDX_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_req_empty(e2), .i_chn_mask(m2),
        .i_receive_req(r2), .o_sel_chn(c2), .o_sel_idx(i2),
        .o_sel_valid(v2), .o_starve_cnt(s2));

    req_arbiter_rr #(.CHN_NUM(16), .PRIO_EN(1), .STARVE_LIM(8), .IDX_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .i_req_empty(e16), .i_chn_mask(m16),
        .i_receive_req(r16), .o_sel_chn(c16), .o_sel_idx(i16),
        .o_sel_valid(v16), .o_starve_cnt(s16));

    typedef struct {
        int idx;
        int stv;
    } sb_t;

    sb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int stv);
        sb_t e;
        e.idx = idx;
        e.stv = stv;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic v, input logic [31:0] chn,
                           input logic [31:0] idx, input logic [31:0] stv);
        sb_t e;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(v), 32'd1);
            chk({tag, "_idx"}, idx, 32'(e.idx));
            chk({tag, "_chn"}, chn, 32'd1 << e.idx);
            chk({tag, "_stv"}, stv, 32'(e.stv));
        end
    endtask

    task automatic pop_main(input string tag);
        pop_chk(tag, sel_valid, 32'(sel_chn), 32'(sel_idx), 32'(starve));
    endtask

    initial begin
        rst_n = 1'b0;
        empty = '1;
        mask  = '1;
        recv  = 1'b0;
        e2    = '1;
        m2    = '1;
        r2    = 1'b0;
        e16   = '1;
        m16   = '1;
        r16   = 1'b0;
        repeat (3) tick();

        chk("rst_chn", 32'(sel_chn), 32'd0);
        chk("rst_idx", 32'(sel_idx), 32'd0);
        chk("rst_valid", 32'(sel_valid), 32'd0);
        chk("rst_stv", 32'(starve), 32'd0);

        // Channels 1,3,5 pending, consumer always ready
        empty = ~7'b0101010;
        recv  = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("first_edge_valid", 32'(sel_valid), 32'd0);
        push(1, 0); push(3, 0); push(5, 0);
        push(1, 0); push(3, 0); push(5, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            pop_main("rr135");
            if (i < 5) tick();
        end
        recv  = 1'b0;
        empty = '1;
        tick();
        chk("hold_valid", 32'(sel_valid), 32'd1);
        chk("hold_idx", 32'(sel_idx), 32'd5);
        recv = 1'b1;
        tick();
        chk("drain_valid", 32'(sel_valid), 32'd0);
        chk("drain_idx", 32'(sel_idx), 32'd5);
        chk("drain_chn", 32'(sel_chn), 32'h20);

        // Single channel 4, then everything empty
        recv  = 1'b0;
        empty = ~7'b0010000;
        push(4, 0);
        tick();
        pop_main("ch4");
        recv  = 1'b1;
        empty = '1;
        tick();
        chk("ch4_idle_valid", 32'(sel_valid), 32'd0);
        chk("ch4_idle_chn", 32'(sel_chn), 32'h10);
        chk("ch4_idle_idx", 32'(sel_idx), 32'd4);

        // Channels 0 and 2: eight priority grants, then the ring gets one
        empty = ~7'b0000101;
        for (int k = 1; k <= 8; k++) push(0, k);
        push(2, 0);
        push(0, 1);
        tick();
        for (int i = 0; i < 10; i++) begin
            pop_main("starve");
            if (i == 9) empty = '1;
            tick();
        end
        chk("starve_idle_valid", 32'(sel_valid), 32'd0);

        // Channel 2 pending for a single cycle is still granted
        recv  = 1'b0;
        empty = ~7'b0000100;
        push(2, 0);
        tick();
        empty = '1;
        pop_main("oneshot2");
        recv = 1'b1;
        tick();
        chk("oneshot_idle", 32'(sel_valid), 32'd0);

        // Starved channel 0 alone still granted, count clears
        empty = ~7'b0000101;
        for (int k = 1; k <= 8; k++) push(0, k);
        push(0, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            pop_main("fallback");
            if (i == 7) empty = ~7'b0000001;
            if (i == 8) empty = '1;
            tick();
        end
        chk("fallback_idle", 32'(sel_valid), 32'd0);

        // Masked channel 6 is ignored until enabled
        recv  = 1'b0;
        mask  = 7'b0111111;
        empty = ~7'b1000000;
        repeat (3) begin
            tick();
            chk("masked_valid", 32'(sel_valid), 32'd0);
        end
        mask = '1;
        push(6, 0);
        tick();
        pop_main("unmask6");

        // Asynchronous reset while holding channel 3
        recv  = 1'b1;
        empty = ~7'b0001000;
        push(3, 0);
        tick();
        pop_main("pre_rst3");
        recv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_chn", 32'(sel_chn), 32'd0);
        chk("arst_idx", 32'(sel_idx), 32'd0);
        chk("arst_valid", 32'(sel_valid), 32'd0);
        chk("arst_stv", 32'(starve), 32'd0);
        empty = ~7'b0001010;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_edge1", 32'(sel_valid), 32'd0);
        push(1, 0);
        tick();
        pop_main("post_rst");
        recv = 1'b1;
        push(3, 0);
        tick();
        pop_main("post_rst_next");
        empty = '1;
        tick();
        chk("post_rst_idle", 32'(sel_valid), 32'd0);

        // Two-channel full ring
        e2 = 2'b00;
        r2 = 1'b1;
        push(0, 0); push(1, 0); push(0, 0); push(1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            pop_chk("n2", v2, 32'(c2), 32'(i2), 32'(s2));
            if (i == 3) e2 = '1;
            tick();
        end
        chk("n2_idle", 32'(v2), 32'd0);

        // Sixteen channels, ring wrap between 15 and 1
        e16 = ~16'h8002;
        r16 = 1'b1;
        push(1, 0); push(15, 0); push(1, 0); push(15, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            pop_chk("n16", v16, 32'(c16), 32'(i16), 32'(s16));
            if (i == 3) e16 = '1;
            tick();
        end
        chk("n16_idle", 32'(v16), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
